// File: rtl/sram_1r_read_arbiter.sv
// ---------------------------------------------------------------------------
// sram_1r_read_arbiter
//
// Burst read controller and two-way round-robin arbiter in front of the
// single-read-port input buffer SRAM. Each requester asks for a burst of
// consecutive bytes (start address + length-1). The winner's burst is read one
// byte at a time. Each address is held for READ_WAIT cycles before capture,
// which covers the SRAM's combinational output delay. The captured byte goes
// back to the owner with a one-cycle valid strobe.
//
// Ports:
//   clock, reset_n         rising-edge clock, synchronous active-low reset
//   Req0/1                 burst request (level, held until Ack)
//   Addr0/1                burst start address (sampled on the grant edge)
//   Len0/1                 burst length minus one
//   Ack0/1                 one-cycle pulse: burst accepted
//   Data0/1                returned byte (holds between strobes)
//   Data0Valid/Data1Valid  one-cycle strobe qualifying Data0/1
//   Done0/1                one-cycle pulse with the last byte of a burst
//   SramAddr               registered SRAM read address
//   SramData               SRAM read bus (combinational)
//   Busy                   high while a burst is in progress
// ---------------------------------------------------------------------------
module sram_1r_read_arbiter #(
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 8,
  parameter int READ_WAIT = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              Req0,
  input  logic [ADDR_W-1:0] Addr0,
  input  logic [ADDR_W-1:0] Len0,
  output logic              Ack0,
  output logic [DATA_W-1:0] Data0,
  output logic              Data0Valid,
  output logic              Done0,
  input  logic              Req1,
  input  logic [ADDR_W-1:0] Addr1,
  input  logic [ADDR_W-1:0] Len1,
  output logic              Ack1,
  output logic [DATA_W-1:0] Data1,
  output logic              Data1Valid,
  output logic              Done1,
  output logic [ADDR_W-1:0] SramAddr,
  input  logic [DATA_W-1:0] SramData,
  output logic              Busy
);

  localparam int WAIT_W = (READ_WAIT > 1) ? $clog2(READ_WAIT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_RELOAD = WAIT_W'(READ_WAIT - 1);

  if (READ_WAIT < 1) begin : g_bad_read_wait
    $error("READ_WAIT must be at least 1");
  end

  typedef enum logic {IDLE, RUN} state_t;

  state_t            r_state;
  logic              r_last_grant;
  logic              r_owner;
  logic [ADDR_W-1:0] r_remaining;
  logic [WAIT_W-1:0] r_wait;
  logic [ADDR_W-1:0] r_sram_addr;
  logic              r_busy;
  logic              r_ack0, r_ack1;
  logic              r_vld0, r_vld1;
  logic              r_done0, r_done1;
  logic [DATA_W-1:0] r_data0, r_data1;

  logic w_any_req;
  logic w_grant_sel;

  // On contention the requester that did not win last time gets the port.
  assign w_any_req   = Req0 | Req1;
  assign w_grant_sel = (Req0 & Req1) ? ~r_last_grant : Req1;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_last_grant <= 1'b1;
      r_owner      <= 1'b0;
      r_remaining  <= '0;
      r_wait       <= '0;
      r_sram_addr  <= '0;
      r_busy       <= 1'b0;
      r_ack0       <= 1'b0;
      r_ack1       <= 1'b0;
      r_vld0       <= 1'b0;
      r_vld1       <= 1'b0;
      r_done0      <= 1'b0;
      r_done1      <= 1'b0;
      r_data0      <= '0;
      r_data1      <= '0;
    end else begin
      r_ack0  <= 1'b0;
      r_ack1  <= 1'b0;
      r_vld0  <= 1'b0;
      r_vld1  <= 1'b0;
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_owner      <= w_grant_sel;
            r_last_grant <= w_grant_sel;
            r_sram_addr  <= w_grant_sel ? Addr1 : Addr0;
            r_remaining  <= w_grant_sel ? Len1 : Len0;
            r_wait       <= WAIT_RELOAD;
            r_ack0       <= ~w_grant_sel;
            r_ack1       <= w_grant_sel;
            r_busy       <= 1'b1;
            r_state      <= RUN;
          end
        end
        RUN: begin
          if (r_wait == '0) begin
            // Address has been stable for READ_WAIT cycles: capture now.
            if (r_owner) begin
              r_data1 <= SramData;
              r_vld1  <= 1'b1;
              r_done1 <= (r_remaining == '0);
            end else begin
              r_data0 <= SramData;
              r_vld0  <= 1'b1;
              r_done0 <= (r_remaining == '0);
            end
            if (r_remaining == '0) begin
              r_busy  <= 1'b0;
              r_state <= IDLE;
            end else begin
              // Natural wrap at the top of the address space.
              r_sram_addr <= r_sram_addr + ADDR_W'(1);
              r_remaining <= r_remaining - ADDR_W'(1);
              r_wait      <= WAIT_RELOAD;
            end
          end else begin
            r_wait <= r_wait - WAIT_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign Ack0       = r_ack0;
  assign Ack1       = r_ack1;
  assign Data0      = r_data0;
  assign Data1      = r_data1;
  assign Data0Valid = r_vld0;
  assign Data1Valid = r_vld1;
  assign Done0      = r_done0;
  assign Done1      = r_done1;
  assign SramAddr   = r_sram_addr;
  assign Busy       = r_busy;

endmodule

// File: tb/tb_sram_1r_read_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sram_1r_read_arbiter
//
// Two instances share clock and reset: index 0 uses READ_WAIT=1, index 1 uses
// READ_WAIT=4. Each instance reads its own copy of the same SRAM image
// (mem[i] = i ^ 8'hA5). Expected bytes, arbitration order and strobe timing come
// from a small model: byte k of a burst is mem[(addr+k) mod 1024] at grant
// edge + (k+1)*READ_WAIT, and contention goes to the port that did not win last.
// ---------------------------------------------------------------------------
module tb_sram_1r_read_arbiter;

  localparam int AW = 10;
  localparam int DW = 8;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic                       reset_n;
  logic [1:0][1:0]            req;
  logic [1:0][1:0][AW-1:0]    addr;
  logic [1:0][1:0][AW-1:0]    len;
  wire  [1:0][1:0]            ack;
  wire  [1:0][1:0]            vld;
  wire  [1:0][1:0]            done;
  wire  [1:0][1:0][DW-1:0]    data;
  wire  [1:0][AW-1:0]         sram_addr;
  wire  [1:0][DW-1:0]         sram_data;
  wire  [1:0]                 busy;

  logic [DW-1:0] mem [1024];

  assign sram_data[0] = mem[sram_addr[0]];
  assign sram_data[1] = mem[sram_addr[1]];

  sram_1r_read_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_WAIT(1)) u_dut_rw1 (
    .clock(clock), .reset_n(reset_n),
    .Req0(req[0][0]), .Addr0(addr[0][0]), .Len0(len[0][0]), .Ack0(ack[0][0]),
    .Data0(data[0][0]), .Data0Valid(vld[0][0]), .Done0(done[0][0]),
    .Req1(req[0][1]), .Addr1(addr[0][1]), .Len1(len[0][1]), .Ack1(ack[0][1]),
    .Data1(data[0][1]), .Data1Valid(vld[0][1]), .Done1(done[0][1]),
    .SramAddr(sram_addr[0]), .SramData(sram_data[0]), .Busy(busy[0])
  );

  sram_1r_read_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_WAIT(4)) u_dut_rw4 (
    .clock(clock), .reset_n(reset_n),
    .Req0(req[1][0]), .Addr0(addr[1][0]), .Len0(len[1][0]), .Ack0(ack[1][0]),
    .Data0(data[1][0]), .Data0Valid(vld[1][0]), .Done0(done[1][0]),
    .Req1(req[1][1]), .Addr1(addr[1][1]), .Len1(len[1][1]), .Ack1(ack[1][1]),
    .Data1(data[1][1]), .Data1Valid(vld[1][1]), .Done1(done[1][1]),
    .SramAddr(sram_addr[1]), .SramData(sram_data[1]), .Busy(busy[1])
  );

  int n_assert = 0;
  int n_fail   = 0;
  int last_grant [2];

  function automatic int rw_of(input int d);
    return (d == 0) ? 1 : 4;
  endfunction

  function automatic logic [DW-1:0] ref_byte(input int a);
    return mem[a % 1024];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Requests must already be driven; the next edge is the grant edge.
  task automatic run_burst(input int d, input int p, input int a, input int l);
    int q;
    int rw;
    int n;
    logic [DW-1:0] other_data;
    q  = 1 - p;
    rw = rw_of(d);
    n  = l + 1;
    other_data = data[d][q];
    tick();
    chk("grant_ack", ack[d][p], 1);
    chk("grant_ack_other", ack[d][q], 0);
    chk("grant_busy", busy[d], 1);
    chk("grant_vld", vld[d], 0);
    last_grant[d] = p;
    // Inputs of the owner are ignored once the burst runs.
    req[d][p]  = 1'b0;
    addr[d][p] = AW'($urandom);
    len[d][p]  = AW'($urandom);
    for (int k = 0; k < n; k++) begin
      for (int w = 1; w <= rw; w++) begin
        chk("addr_hold", sram_addr[d], (a + k) % 1024);
        tick();
        chk("ack_quiet", ack[d], 0);
        chk("other_quiet", {vld[d][q], done[d][q]}, 0);
        if (w < rw) begin
          chk("strobe_early", {vld[d][p], done[d][p]}, 0);
        end else begin
          chk("valid", vld[d][p], 1);
          chk("data", data[d][p], ref_byte(a + k));
          chk("done", done[d][p], (k == n - 1));
        end
      end
    end
    chk("other_data_hold", data[d][q], other_data);
    chk("addr_after_last", sram_addr[d], (a + n - 1) % 1024);
  endtask

  task automatic serve(input int d, input bit r0, input bit r1,
                       input int a0, input int l0, input int a1, input int l1);
    int first;
    req[d][0]  = r0;
    req[d][1]  = r1;
    addr[d][0] = AW'(a0);
    len[d][0]  = AW'(l0);
    addr[d][1] = AW'(a1);
    len[d][1]  = AW'(l1);
    if (r0 && r1) first = (last_grant[d] == 1) ? 0 : 1;
    else          first = r1 ? 1 : 0;
    run_burst(d, first, first ? a1 : a0, first ? l1 : l0);
    if (r0 && r1) run_burst(d, 1 - first, first ? a0 : a1, first ? l0 : l1);
  endtask

  task automatic idle_check(input int d);
    logic [AW-1:0] held;
    held = sram_addr[d];
    tick();
    chk("idle_busy", busy[d], 0);
    chk("idle_ack", ack[d], 0);
    chk("idle_vld", vld[d], 0);
    chk("idle_done", done[d], 0);
    chk("idle_addr_hold", sram_addr[d], held);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = DW'(i) ^ 8'hA5;
    req  = '0;
    addr = '0;
    len  = '0;
    reset_n = 1'b0;
    last_grant[0] = 1;
    last_grant[1] = 1;

    // Reset state of both instances.
    tick();
    tick();
    for (int d = 0; d < 2; d++) begin
      chk("rst_busy", busy[d], 0);
      chk("rst_ack", ack[d], 0);
      chk("rst_vld", vld[d], 0);
      chk("rst_done", done[d], 0);
      chk("rst_data0", data[d][0], 0);
      chk("rst_data1", data[d][1], 0);
      chk("rst_sram_addr", sram_addr[d], 0);
    end
    reset_n = 1'b1;

    // Contention right after reset: port 0 first, then port 1, twice.
    serve(0, 1'b1, 1'b1, 10, 1, 20, 1);
    serve(0, 1'b1, 1'b1, 30, 1, 40, 1);
    idle_check(0);

    // Single 4-byte burst from address 5.
    serve(0, 1'b1, 1'b0, 5, 3, 0, 0);
    chk("t1_last_byte", data[0][0], 8'hAD);
    idle_check(0);

    // Address wrap 1022 -> 1023 -> 0 on port 1.
    serve(0, 1'b0, 1'b1, 0, 0, 1022, 2);
    chk("wrap_last_byte", data[0][1], 8'hA5);
    idle_check(0);

    // Maximum-length burst.
    serve(0, 1'b1, 1'b0, 0, 1023, 0, 0);
    idle_check(0);

    // Reset during an 8-byte burst after the second byte.
    req[0][0]  = 1'b1;
    addr[0][0] = AW'(100);
    len[0][0]  = AW'(7);
    tick();
    chk("mid_ack", ack[0][0], 1);
    tick();
    chk("mid_vld1", vld[0][0], 1);
    chk("mid_data1", data[0][0], ref_byte(100));
    tick();
    chk("mid_vld2", vld[0][0], 1);
    chk("mid_data2", data[0][0], ref_byte(101));
    reset_n = 1'b0;
    tick();
    chk("abort_busy", busy[0], 0);
    chk("abort_ack", ack[0], 0);
    chk("abort_vld", vld[0], 0);
    chk("abort_done", done[0], 0);
    chk("abort_data0", data[0][0], 0);
    chk("abort_data1", data[0][1], 0);
    chk("abort_sram_addr", sram_addr[0], 0);
    last_grant[0] = 1;
    last_grant[1] = 1;
    reset_n = 1'b1;
    run_burst(0, 0, 100, 7);
    idle_check(0);

    // READ_WAIT=4: 3-byte burst, strobes four cycles apart.
    serve(1, 1'b1, 1'b0, 300, 2, 0, 0);
    idle_check(1);
    serve(1, 1'b1, 1'b1, 1021, 3, 7, 1);
    idle_check(1);

    // Randomized traffic on both instances.
    for (int d = 0; d < 2; d++) begin
      for (int it = 0; it < 12; it++) begin
        int pat;
        pat = int'($urandom_range(1, 3));
        serve(d, (pat & 1) != 0, (pat & 2) != 0,
              int'($urandom_range(0, 1023)), int'($urandom_range(0, 5)),
              int'($urandom_range(0, 1023)), int'($urandom_range(0, 5)));
        idle_check(d);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_1r_read_arbiter.md
Name: sram_1r_read_arbiter

Overview:
Burst read controller and two-way arbiter for the 1024x8 single-read-port input buffer SRAM in the Bellman-Ford datapath. Two requesters (e.g. edge-list fetch and node-table fetch) each request a burst of consecutive bytes by start address and length. The block grants the read port round-robin, drives the SRAM address, and waits out the memory's 4 ns combinational output delay. It captures each byte and returns it to the owning requester with a valid strobe.

Parameters:
ADDR_W, 10, SRAM address width; 1024 words.
DATA_W, 8, SRAM word width.
READ_WAIT, 1, clock cycles the address is held before capture; must be >= 1, and clock period * READ_WAIT must exceed 4 ns.

Ports:
clock  in  1  system clock; all logic on the rising edge.
reset_n  in  1  synchronous active-low reset.
Req0  in  1  requester 0 burst request; level, held until Ack0.
Addr0  in  ADDR_W  requester 0 start address; sampled on the grant edge.
Len0  in  ADDR_W  requester 0 burst length minus 1 (0..1023 encodes 1..1024 bytes).
Ack0  out  1  one-cycle pulse: requester 0 burst accepted.
Data0  out  DATA_W  byte returned to requester 0.
Data0Valid  out  1  one-cycle strobe qualifying Data0.
Done0  out  1  one-cycle pulse with the last Data0Valid of a burst.
Req1, Addr1, Len1, Ack1, Data1, Data1Valid, Done1  same as requester 0, for requester 1.
SramAddr  out  ADDR_W  registered read address to the SRAM ReadAddress.
SramData  in  DATA_W  SRAM ReadBus (combinational, 4 ns delay).
Busy  out  1  high while a burst is in progress.

Behaviour:
- Reset (reset_n=0 at an edge):
  - state=IDLE; all Ack/Valid/Done/Busy=0.
  - Data0, Data1, SramAddr = 0.
  - LastGrant=1, so requester 0 wins the first contention.
  - Internal wait and byte counters = 0.
  - Reset mid-burst aborts immediately: no further Valid, no Done.
- States: IDLE, RUN.
- IDLE, at edge E0:
  - Only one Req high: grant it.
  - Both Req high: grant the requester other than LastGrant.
  - On grant:
    - AckX=1 for the cycle after E0.
    - SramAddr=AddrX.
    - remaining=LenX; wait counter=READ_WAIT-1.
    - Busy=1; LastGrant=X; go to RUN.
  - No Req: stay in IDLE.
- RUN:
  - Wait counter decrements each edge.
  - At the edge where the wait counter is 0:
    - DataX<=SramData; DataXValid=1 for one cycle.
    - If remaining==0: DoneX=1 in the same cycle, Busy=0, go to IDLE.
    - Otherwise: SramAddr<=SramAddr+1 (modulo 1024, so 1023 wraps to 0), remaining-1, wait counter reloads to READ_WAIT-1.
- Timing:
  - A burst of N bytes produces Valids at edges E0+k*READ_WAIT, k=1..N.
  - The earliest next grant is at edge E0+N*READ_WAIT+1, giving one IDLE bubble between bursts.
- SramAddr is stable for READ_WAIT full cycles before each capture, and stays unchanged while idle.
- Requester signals:
  - Req, Addr and Len are ignored during RUN; dropping Req mid-burst does not abort the burst.
  - Req still high in IDLE after Done is a new request.
  - A pending request on the other port is served next.
- DataX holds its last captured value between strobes. It is meaningful only when DataXValid=1. The other port's Data/Valid/Done are never disturbed.
- Never more than one Ack/Valid/Done asserted across ports in a cycle.

Test Plan:
1. Preload mem[i]=i^8'hA5. Req0 with Addr0=5, Len0=3 -> Ack0 one cycle; Data0Valid on 4 consecutive cycles with 8'hA0, 8'hA3, 8'hA2, 8'hAD; Done0 with 8'hAD; Busy falls the next cycle.
2. Req0 and Req1 both rise the first cycle after reset, each with Len=1 -> requester 0 served first, requester 1 granted one cycle after Done0. Raise both again -> requester 0 served first again (LastGrant=1).
3. Addr1=1022, Len1=2 -> SramAddr sequence 1022, 1023, 0; Data1 = mem[1022], mem[1023], mem[0]; Done1 on the third byte.
4. Addr0=0, Len0=1023 -> exactly 1024 Data0Valid pulses in consecutive cycles; Done0 only on the 1024th; no Data1Valid.
5. Assert reset_n=0 after the 2nd Data0Valid of an 8-byte burst -> all outputs 0 the next cycle, no Done0. Release reset with Req0 still high -> re-grant restarts at Addr0.
6. With READ_WAIT=4 and a 3-byte burst -> SramAddr holds each value 4 cycles; Valids spaced exactly 4 cycles apart; first Valid 4 edges after the grant edge.
